regfile_mp_sb: RTL and testbench

Parametrised successor to the single-cycle core's 2R/1W register file. Supports N combinational read ports and two write ports with fixed priority. Adds an optional write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard for the pipelined core. Sits between decode (read and issue) and writeback (ALU port 0, load/long-latency port 1).

---
 rtl/regfile_mp_sb.sv | 89 ++++++++
 tb/tb_regfile_mp_sb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NRD combinational read ports, two prioritised write ports,
// optional write-to-read bypass, optional hard-wired zero register and a per-register busy scoreboard.
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                areset,
  input  logic [NRD*AW-1:0]   RA,
  output logic [NRD*XLEN-1:0] RD,
  output logic [NRD-1:0]      RBUSY,
  input  logic                WE0,
  input  logic [AW-1:0]       WA0,
  input  logic [XLEN-1:0]     WD0,
  input  logic                WE1,
  input  logic [AW-1:0]       WA1,
  input  logic [XLEN-1:0]     WD1,
  input  logic                SET_EN,
  input  logic [AW-1:0]       SET_A
);

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             we0_eff;
  logic             we1_eff;
  logic             set_eff;

  // Anything aimed at the zero register is dropped before it reaches storage, scoreboard or bypass.
  assign we0_eff = WE0 && !(ZERO_REG != 0 && WA0 == '0);
  assign we1_eff = WE1 && !(ZERO_REG != 0 && WA1 == '0);
  assign set_eff = SET_EN && !(ZERO_REG != 0 && SET_A == '0);

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (we0_eff) busy_next[WA0] = 1'b0;
    if (we1_eff) busy_next[WA1] = 1'b0;
    if (set_eff) busy_next[SET_A] = 1'b1;  // a new producer overrides the retiring one
  end

  // NOTE: the storage array is reset because software relies on all registers reading 0 after reset.
  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (we0_eff) regs[WA0] <= WD0;
      if (we1_eff) regs[WA1] <= WD1;  // port 1 wins an address collision
      busy <= busy_next;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign ra = RA[p*AW +: AW];

    always_comb begin
      data = regs[ra];
      bsy  = busy[ra];
      // A bypassed write carries its data now, so the consumer need not wait on it.
      if (BYPASS != 0 && areset) begin
        if (we1_eff && WA1 == ra) begin
          data = WD1;
          bsy  = 1'b0;
        end else if (we0_eff && WA0 == ra) begin
          data = WD0;
          bsy  = 1'b0;
        end
      end
      if (ZERO_REG != 0 && ra == '0) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign RD[p*XLEN +: XLEN] = data;
    assign RBUSY[p]           = bsy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: two configurations (4 ports/bypass/zero-reg and 2 ports/no bypass/no zero-reg)
// share write and scoreboard stimulus and are compared against a behavioural array model.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam bit [1:0] ZR = 2'b01;  // config 0 has a zero register, config 1 does not
  localparam bit [1:0] BP = 2'b01;  // config 0 bypasses, config 1 does not

  logic            clk;
  logic            areset;
  logic [4*AW-1:0] ra_a;
  logic [2*AW-1:0] ra_b;
  logic [4*XLEN-1:0] rd_a;
  logic [2*XLEN-1:0] rd_b;
  logic [3:0]      rbusy_a;
  logic [1:0]      rbusy_b;
  logic            we0, we1, set_en;
  logic [AW-1:0]   wa0, wa1, set_a;
  logic [XLEN-1:0] wd0, wd1;

  int checks;
  int failures;

  logic [XLEN-1:0] mem [2][DEPTH];
  bit              bsy [2][DEPTH];

  regfile_mp_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .CLK(clk), .areset(areset), .RA(ra_a), .RD(rd_a), .RBUSY(rbusy_a),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .SET_EN(set_en), .SET_A(set_a)
  );

  regfile_mp_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .CLK(clk), .areset(areset), .RA(ra_b), .RD(rd_b), .RBUSY(rbusy_b),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .SET_EN(set_en), .SET_A(set_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < DEPTH; a++) begin
        mem[c][a] = '0;
        bsy[c][a] = 1'b0;
      end
  endtask

  // Effect of one clock edge on each configuration's architectural state.
  task automatic model_commit();
    for (int c = 0; c < 2; c++) begin
      if (we0 && !(ZR[c] && wa0 == 0)) begin
        mem[c][wa0] = wd0;
        bsy[c][wa0] = 1'b0;
      end
      if (we1 && !(ZR[c] && wa1 == 0)) begin
        mem[c][wa1] = wd1;
        bsy[c][wa1] = 1'b0;
      end
      if (set_en && !(ZR[c] && set_a == 0)) bsy[c][set_a] = 1'b1;
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(int c, logic [AW-1:0] a);
    if (ZR[c] && a == 0) return '0;
    if (BP[c] && we1 && wa1 == a) return wd1;
    if (BP[c] && we0 && wa0 == a) return wd0;
    return mem[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [AW-1:0] a);
    if (ZR[c] && a == 0) return 1'b0;
    if (BP[c] && ((we1 && wa1 == a) || (we0 && wa0 == a))) return 1'b0;
    return bsy[c][a];
  endfunction

  task automatic check_all(string tag);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s_a_rd%0d", tag, p), rd_a[p*XLEN +: XLEN], exp_rd(0, ra_a[p*AW +: AW]));
      check($sformatf("%s_a_busy%0d", tag, p), {31'd0, rbusy_a[p]}, {31'd0, exp_busy(0, ra_a[p*AW +: AW])});
    end
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s_b_rd%0d", tag, p), rd_b[p*XLEN +: XLEN], exp_rd(1, ra_b[p*AW +: AW]));
      check($sformatf("%s_b_busy%0d", tag, p), {31'd0, rbusy_b[p]}, {31'd0, exp_busy(1, ra_b[p*AW +: AW])});
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; set_en = 1'b0;
  endtask

  task automatic set_ra(logic [AW-1:0] a);
    ra_a = {4{a}};
    ra_b = {2{a}};
  endtask

  // Check during the cycle (bypass view), take the edge, drop the strobes, check the stored view.
  task automatic cycle(string tag);
    #1 check_all({tag, "_pre"});
    @(posedge clk);
    model_commit();
    #1 idle();
    #1 check_all({tag, "_post"});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    areset = 1'b0;
    idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; set_a = '0;
    set_ra('0);
    model_reset();

    #1 check_all("reset");
    @(posedge clk);
    #1 areset = 1'b1;

    // Reset: r5 written and r6 busy, then an asynchronous pulse between edges.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; set_en = 1'b1; set_a = 5'd6;
    ra_a = {5'd6, 5'd5, 5'd6, 5'd5}; ra_b = {5'd6, 5'd5};
    cycle("rst_setup");
    areset = 1'b0;
    model_reset();
    #1 check_all("rst_pulse");
    #1 areset = 1'b1;

    // Reset held across an edge discards the write in flight.
    @(posedge clk);
    #1 we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hCAFEF00D; areset = 1'b0;
    @(posedge clk);
    #1 areset = 1'b1; idle();
    #1 check_all("rst_mid");

    // Bypass on port 0.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678; set_ra(5'd7);
    cycle("bypass");

    // Same-address collision: port 1 wins.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1; we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h2; set_ra(5'd3);
    cycle("collide");

    // Zero register write and set.
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; set_en = 1'b1; set_a = 5'd0; set_ra(5'd0);
    cycle("zero");

    // Scoreboard on r9: set, set+write (set wins), then a retiring write.
    set_en = 1'b1; set_a = 5'd9; set_ra(5'd9);
    cycle("sb_set");
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hAA; set_en = 1'b1; set_a = 5'd9;
    cycle("sb_setwr");
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55;
    cycle("sb_clear");

    // Per-port slices: r1..r4 hold 0x11..0x44, r2 busy.
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h22;
    cycle("sweep_w12");
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44;
    set_en = 1'b1; set_a = 5'd2;
    cycle("sweep_w34");
    ra_a = {5'd4, 5'd3, 5'd2, 5'd1}; ra_b = {5'd2, 5'd1};
    #1 check_all("sweep");
    ra_a = {5'd1, 5'd2, 5'd3, 5'd4}; ra_b = {5'd4, 5'd3};
    #1 check_all("sweep_rev");

    // Randomised traffic concentrated on a few registers to provoke hits and collisions.
    for (int n = 0; n < 150; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom();
      we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom();
      set_en = 1'($urandom_range(0, 1)); set_a = 5'($urandom_range(0, 7));
      for (int p = 0; p < 4; p++) ra_a[p*AW +: AW] = 5'($urandom_range(0, (n % 10 == 0) ? 31 : 7));
      for (int p = 0; p < 2; p++) ra_b[p*AW +: AW] = 5'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
